// File: rtl/axis_decimator_pkg.sv
// rtl/axis_decimator_pkg.sv - shared constants for the AXI-Stream decimator
package axis_decimator_pkg;

  localparam int BUS_WIDTH_DEFAULT = 2;
  localparam int DATA_WIDTH        = BUS_WIDTH_DEFAULT * 8;
  localparam int RATE_PASS         = 1;
  localparam int DROP_CNT_W        = 32;

  // The group counter never exceeds R_eff-1, so the rate width is enough.
  function automatic int cnt_width(input int rate_width);
    return rate_width;
  endfunction

endpackage

// File: rtl/axis_decimator_skid.sv
// rtl/axis_decimator_skid.sv - output register plus one-entry skid buffer
// Ready is registered: it is the inverse of next-cycle skid occupancy.
module axis_decimator_skid
  import axis_decimator_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] in_tdata_i,
  input  logic          in_tvalid_i,
  output logic          in_tready_o,
  output logic [DW-1:0] out_tdata_o,
  output logic          out_tvalid_o,
  input  logic          out_tready_i
);

  logic [DW-1:0] out_data_q, out_data_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          ready_q, ready_d;
  logic          push, pop;

  assign push = in_tvalid_i & ready_q;
  assign pop  = out_valid_q & out_tready_i;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    // ready_q is low whenever the skid holds data, so push and skid refill never collide
    if (pop && skid_valid_q) begin
      out_data_d   = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (push && (!out_valid_q || pop)) begin
      out_data_d  = in_tdata_i;
      out_valid_d = 1'b1;
    end else if (push) begin
      skid_data_d  = in_tdata_i;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_tready_o  = ready_q;
  assign out_tdata_o  = out_data_q;
  assign out_tvalid_o = out_valid_q;

endmodule

// File: rtl/axis_decimator.sv
// rtl/axis_decimator.sv - keeps the last beat of every R accepted beats
// Optional drop counter port enabled by AXIS_DECIMATOR_COUNT_EN.
module axis_decimator
  import axis_decimator_pkg::*;
#(
  parameter int BUS_WIDTH  = BUS_WIDTH_DEFAULT,
  parameter int RATE_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [RATE_WIDTH-1:0]  rate,
  input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
`ifdef AXIS_DECIMATOR_COUNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_count
`endif
);

  localparam int DW = BUS_WIDTH * 8;
  localparam int CW = cnt_width(RATE_WIDTH);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic [RATE_WIDTH-1:0] rate_eff, rate_cur;
  logic                  skid_tready;
  logic                  accept, last_of_group, keep;

  assign rate_eff = (rate == '0) ? RATE_WIDTH'(RATE_PASS) : rate;
  // The first beat of a group uses the live rate; later beats use the latched one
  assign rate_cur      = (cnt_q == '0) ? rate_eff : rate_q;
  assign accept        = s_axis_tvalid & skid_tready;
  assign last_of_group = (cnt_q == CW'(rate_cur - RATE_WIDTH'(1)));
  assign keep          = accept & last_of_group;

  always_comb begin
    cnt_d  = cnt_q;
    rate_d = rate_q;
    if (accept) begin
      if (cnt_q == '0) begin
        rate_d = rate_eff;
      end
      cnt_d = last_of_group ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      cnt_q  <= '0;
      rate_q <= RATE_WIDTH'(RATE_PASS);
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

  axis_decimator_skid #(
    .DW(DW)
  ) u_skid (
    .clk_i       (aclk),
    .rst_ni      (arstn),
    .in_tdata_i  (s_axis_tdata),
    .in_tvalid_i (keep),
    .in_tready_o (skid_tready),
    .out_tdata_o (m_axis_tdata),
    .out_tvalid_o(m_axis_tvalid),
    .out_tready_i(m_axis_tready)
  );

  assign s_axis_tready = skid_tready;

`ifdef AXIS_DECIMATOR_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && !last_of_group && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule
